// File: rtl/ucca_conf_if.sv
// Data-bus, PC and region-monitor signals of the UCC configuration block.
// The master side drives bus accesses. The slave side is the configuration block.
interface ucca_conf_if;
  logic [15:0] pc;
  logic        data_en;
  logic        data_wr;
  logic [15:0] data_addr;
  logic [15:0] data_wdata;
  logic        region_reset;
  logic [15:0] data_rdata;
  logic [15:0] ucc_min;
  logic [15:0] ucc_max;
  logic        ucc_valid;
  logic        conf_reset;

  modport master (
    output pc, data_en, data_wr, data_addr, data_wdata, region_reset,
    input  data_rdata, ucc_min, ucc_max, ucc_valid, conf_reset
  );

  modport slave (
    input  pc, data_en, data_wr, data_addr, data_wdata, region_reset,
    output data_rdata, ucc_min, ucc_max, ucc_valid, conf_reset
  );
endinterface

// File: rtl/ucca_conf.sv
// Memory-mapped UCC bounds configuration with an arm/lock FSM and violation logging.
// Reads have 1-cycle latency. Illegal writes are dropped and answered with a one-cycle conf_reset pulse.
module ucca_conf #(
  parameter logic [15:0] CONF_BASE = 16'h0160,
  parameter int          VCNT_W    = 16
) (
  input logic     clk,
  input logic     system_reset,
  ucca_conf_if.slave bus
);

  typedef enum logic [1:0] {UNCONF, ARMED, LOCKED} state_t;

  state_t            r_state;
  logic              r_valid;
  logic [15:0]       r_min;
  logic [15:0]       r_max;
  logic [15:0]       r_last_pc;
  logic [15:0]       r_rdata;
  logic [VCNT_W-1:0] r_vcnt;
  logic              r_cfg_err;
  logic              r_viol;
  logic              r_conf_reset;

  logic [15:0] w_offset;
  logic        w_hit;
  logic        w_wr_hit;
  logic        w_rd_hit;
  logic        w_in_region;
  logic        w_drop;
  logic        w_wr_ok;
  logic        w_arm_ok;
  logic [15:0] w_status;
  logic [15:0] w_rd_mux;

  assign w_offset    = bus.data_addr - CONF_BASE;
  assign w_hit       = bus.data_en && !bus.data_addr[0] &&
                       (bus.data_addr >= CONF_BASE) && (w_offset <= 16'h000B);
  assign w_wr_hit    = w_hit && bus.data_wr;
  assign w_rd_hit    = w_hit && !bus.data_wr;
  assign w_in_region = r_valid && (bus.pc >= r_min) && (bus.pc <= r_max);
  // Code running inside the protected region must never reconfigure it.
  assign w_drop      = w_wr_hit && ((r_state == LOCKED) || w_in_region);
  assign w_wr_ok     = w_wr_hit && !w_drop;
  assign w_arm_ok    = (r_min <= r_max) && !r_min[0] && !r_max[0];
  assign w_status    = {12'b0, r_viol, r_cfg_err, (r_state == LOCKED), r_valid};

  always_comb begin
    w_rd_mux = 16'h0000;
    case (w_offset[3:0])
      4'h0:    w_rd_mux = r_min;
      4'h2:    w_rd_mux = r_max;
      4'h6:    w_rd_mux = w_status;
      4'h8:    w_rd_mux = 16'(r_vcnt);
      4'hA:    w_rd_mux = r_last_pc;
      default: w_rd_mux = 16'h0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (system_reset) begin
      r_state      <= UNCONF;
      r_valid      <= 1'b0;
      r_min        <= 16'hFFFF;
      r_max        <= 16'h0000;
      r_last_pc    <= 16'h0000;
      r_rdata      <= 16'h0000;
      r_vcnt       <= '0;
      r_cfg_err    <= 1'b0;
      r_viol       <= 1'b0;
      r_conf_reset <= 1'b0;
    end else begin
      r_conf_reset <= w_drop;
      r_rdata      <= w_rd_hit ? w_rd_mux : 16'h0000;

      if (bus.region_reset) begin
        if (!(&r_vcnt)) r_vcnt <= r_vcnt + 1'b1;
        r_last_pc <= bus.pc;
        r_viol    <= 1'b1;
      end

      if (w_wr_ok) begin
        case (r_state)
          UNCONF: begin
            case (w_offset[3:0])
              4'h0: r_min <= bus.data_wdata;
              4'h2: r_max <= bus.data_wdata;
              4'h4: begin
                if (bus.data_wdata[0]) begin
                  if (w_arm_ok) begin
                    r_state   <= ARMED;
                    r_valid   <= 1'b1;
                    r_cfg_err <= 1'b0;
                  end else begin
                    r_cfg_err <= 1'b1;
                  end
                end
              end
              default: ;
            endcase
          end
          ARMED: begin
            case (w_offset[3:0])
              4'h0: begin
                r_min   <= bus.data_wdata;
                r_state <= UNCONF;
                r_valid <= 1'b0;
              end
              4'h2: begin
                r_max   <= bus.data_wdata;
                r_state <= UNCONF;
                r_valid <= 1'b0;
              end
              // LOCK takes precedence over a cleared ARM bit.
              4'h4: begin
                if (bus.data_wdata[1]) begin
                  r_state <= LOCKED;
                end else if (!bus.data_wdata[0]) begin
                  r_state <= UNCONF;
                  r_valid <= 1'b0;
                end
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.data_rdata = r_rdata;
  assign bus.ucc_valid  = r_valid;
  assign bus.ucc_min    = r_valid ? r_min : 16'hFFFF;
  assign bus.ucc_max    = r_valid ? r_max : 16'h0000;
  assign bus.conf_reset = r_conf_reset;

endmodule

// File: tb/tb_ucca_conf.sv
// Bench for ucca_conf: directed scenarios followed by random traffic.
// A behavioural model of the register map checks every cycle.
module tb_ucca_conf;
  localparam logic [15:0] BASE = 16'h0160;
  localparam int          VW   = 4;
  localparam int          VMAX = (1 << VW) - 1;

  logic clk = 1'b0;
  logic system_reset;
  always #5 clk = ~clk;

  ucca_conf_if u_if ();

  ucca_conf #(.CONF_BASE(BASE), .VCNT_W(VW)) dut (
    .clk          (clk),
    .system_reset (system_reset),
    .bus          (u_if.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: armed/locked flags rather than a state encoding.
  bit          m_valid, m_locked, m_cfgerr, m_sticky, m_conf;
  logic [15:0] m_min, m_max, m_lastpc, m_rdata;
  int          m_vcnt;
  logic [15:0] tb_pc = 16'h0000;

  function automatic logic [15:0] m_read(int off);
    case (off)
      0:       return m_min;
      2:       return m_max;
      6:       return {12'b0, m_sticky, m_cfgerr, m_locked, m_valid};
      8:       return 16'(m_vcnt);
      10:      return m_lastpc;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, input bit en, input bit wr, input logic [15:0] addr,
                            input logic [15:0] wd, input logic [15:0] pc, input bit rr);
    int off;
    bit hit, inreg, drop;
    logic [15:0] nrd;
    off = int'(addr) - int'(BASE);
    hit = en && !addr[0] && off >= 0 && off <= 11;
    if (rst) begin
      m_valid = 0; m_locked = 0; m_cfgerr = 0; m_sticky = 0; m_conf = 0;
      m_min = 16'hFFFF; m_max = 16'h0000; m_lastpc = 16'h0000; m_rdata = 16'h0000;
      m_vcnt = 0;
    end else begin
      inreg = m_valid && pc >= m_min && pc <= m_max;
      nrd   = (hit && !wr) ? m_read(off) : 16'h0000;
      drop  = hit && wr && (m_locked || inreg);
      if (hit && wr && !drop) begin
        if (off == 0) begin m_min = wd; m_valid = 0; end
        else if (off == 2) begin m_max = wd; m_valid = 0; end
        else if (off == 4) begin
          if (!m_valid) begin
            if (wd[0]) begin
              if (m_min <= m_max && !m_min[0] && !m_max[0]) begin m_valid = 1; m_cfgerr = 0; end
              else m_cfgerr = 1;
            end
          end else if (wd[1]) m_locked = 1;
          else if (!wd[0]) m_valid = 0;
        end
      end
      if (rr) begin
        if (m_vcnt < VMAX) m_vcnt++;
        m_lastpc = pc;
        m_sticky = 1;
      end
      m_rdata = nrd;
      m_conf  = drop;
    end
  endtask

  task automatic cycle(input bit rst, input bit en, input bit wr, input logic [15:0] addr,
                       input logic [15:0] wd, input logic [15:0] pc, input bit rr);
    system_reset      = rst;
    u_if.data_en      = en;
    u_if.data_wr      = wr;
    u_if.data_addr    = addr;
    u_if.data_wdata   = wd;
    u_if.pc           = pc;
    u_if.region_reset = rr;
    model_step(rst, en, wr, addr, wd, pc, rr);
    @(posedge clk);
    #1;
    check("rdata",      u_if.data_rdata, m_rdata);
    check("conf_reset", 16'(u_if.conf_reset), 16'(m_conf));
    check("ucc_valid",  16'(u_if.ucc_valid), 16'(m_valid));
    check("ucc_min",    u_if.ucc_min, m_valid ? m_min : 16'hFFFF);
    check("ucc_max",    u_if.ucc_max, m_valid ? m_max : 16'h0000);
    @(negedge clk);
  endtask

  task automatic idle();                                   cycle(0, 0, 0, 16'h0, 16'h0, tb_pc, 0); endtask
  task automatic wr(input logic [15:0] a, input logic [15:0] d); cycle(0, 1, 1, a, d, tb_pc, 0); endtask
  task automatic rr_pulse(input logic [15:0] p);           cycle(0, 0, 0, 16'h0, 16'h0, p, 1); endtask
  task automatic rd_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
    cycle(0, 1, 0, a, 16'h0, tb_pc, 0);
    check(tag, u_if.data_rdata, exp);
  endtask

  initial begin
    @(negedge clk);
    cycle(1, 0, 0, 16'h0, 16'h0, 16'h0, 0);
    cycle(1, 0, 0, 16'h0, 16'h0, 16'h0, 0);
    check("rst_valid", 16'(u_if.ucc_valid), 16'h0000);
    check("rst_min",   u_if.ucc_min, 16'hFFFF);
    check("rst_max",   u_if.ucc_max, 16'h0000);
    check("rst_conf",  16'(u_if.conf_reset), 16'h0000);
    rd_check("rst_status", BASE + 16'h6, 16'h0000);

    // Successful arm
    wr(BASE + 16'h0, 16'hE000);
    wr(BASE + 16'h2, 16'hE1FE);
    wr(BASE + 16'h4, 16'h0001);
    check("arm_valid", 16'(u_if.ucc_valid), 16'h0001);
    check("arm_min",   u_if.ucc_min, 16'hE000);
    check("arm_max",   u_if.ucc_max, 16'hE1FE);
    rd_check("arm_status", BASE + 16'h6, 16'h0001);

    // Write from inside the region is dropped
    tb_pc = 16'hE010;
    wr(BASE + 16'h2, 16'hE300);
    check("inreg_conf", 16'(u_if.conf_reset), 16'h0001);
    tb_pc = 16'h0000;
    idle();
    check("inreg_conf_off", 16'(u_if.conf_reset), 16'h0000);
    check("inreg_max",      u_if.ucc_max, 16'hE1FE);

    // Lock, then an illegal write
    wr(BASE + 16'h4, 16'h0003);
    wr(BASE + 16'h0, 16'h0000);
    check("lock_conf", 16'(u_if.conf_reset), 16'h0001);
    idle();
    check("lock_conf_off", 16'(u_if.conf_reset), 16'h0000);
    check("lock_min",      u_if.ucc_min, 16'hE000);
    rd_check("lock_status", BASE + 16'h6, 16'h0003);

    // Violation logging and saturation
    rr_pulse(16'hE004);
    rr_pulse(16'hE008);
    rr_pulse(16'hE00C);
    rd_check("vcnt3",      BASE + 16'h8, 16'h0003);
    rd_check("last_pc",    BASE + 16'hA, 16'hE00C);
    rd_check("viol_stat",  BASE + 16'h6, 16'h000B);
    for (int i = 0; i < VMAX; i++) rr_pulse(16'h1234);
    rd_check("vcnt_sat",   BASE + 16'h8, 16'(VMAX));

    // Reset beats a simultaneous region_reset
    cycle(1, 0, 0, 16'h0, 16'h0, 16'hE004, 1);
    check("rr_rst_valid", 16'(u_if.ucc_valid), 16'h0000);
    check("rr_rst_min",   u_if.ucc_min, 16'hFFFF);
    check("rr_rst_max",   u_if.ucc_max, 16'h0000);
    rd_check("rr_rst_vcnt", BASE + 16'h8, 16'h0000);

    // Bad bounds, then recovery clears cfg_err
    wr(BASE + 16'h0, 16'hE200);
    wr(BASE + 16'h2, 16'hE100);
    wr(BASE + 16'h4, 16'h0001);
    check("bad_valid", 16'(u_if.ucc_valid), 16'h0000);
    rd_check("bad_status", BASE + 16'h6, 16'h0004);
    wr(BASE + 16'h1, 16'h0000);
    rd_check("odd_ignored", BASE + 16'h0, 16'hE200);
    rd_check("out_of_range", BASE + 16'hC, 16'h0000);
    wr(BASE + 16'h0, 16'hE000);
    wr(BASE + 16'h4, 16'h0001);
    rd_check("rearm_status", BASE + 16'h6, 16'h0001);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      bit          r_rst, r_en, r_wr, r_rr;
      logic [15:0] a, d, p;
      r_rst = ($urandom_range(99) == 0);
      r_en  = ($urandom_range(3) != 0);
      r_wr  = ($urandom_range(1) == 1);
      r_rr  = ($urandom_range(7) == 0);
      a = ($urandom_range(7) == 0) ? 16'($urandom) : BASE + 16'($urandom_range(12));
      case ($urandom_range(4))
        0:       d = 16'hE000;
        1:       d = 16'hE1FE;
        2:       d = 16'hE200;
        3:       d = 16'($urandom_range(3));
        default: d = 16'($urandom);
      endcase
      p = ($urandom_range(1) == 1) ? 16'hE000 + 16'($urandom_range(511)) : 16'($urandom);
      cycle(r_rst, r_en, r_wr, a, d, p, r_rr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
